// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the ws2812b strip driver and its write arbiter.
package ws2812b_pkg;

    localparam int COLOR_W         = 24;
    localparam int LED_IDX_W       = 32;
    localparam int DEFAULT_NB_LEDS = 5;

    // GGRRBB color word, identical to the driver's color port
    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ws2812b_rr_pick.sv
// Combinational requester picker for the ws2812b write arbiter.
// Default: round-robin search starting at ptr, wrapping at NUM_REQ.
// With WS2812B_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins
// (ptr is ignored).
module ws2812b_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic found;
    int   cand;

    // First valid requester in search order gets the one-hot grant
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
`ifdef WS2812B_ARB_FIXED_PRIO_EN
            cand = off;
`else
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`endif
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ws2812b_write_arbiter.sv
// Shares the ws2812b driver's color/nb_led/write port among NUM_REQ
// requesters. Each request is a fill of one color over a run of LEDs; fills
// are serialised one LED slot per cycle. Out-of-range slots take a cycle with
// write low so fill timing depends only on the count.
// Optional macro WS2812B_ARB_FIXED_PRIO_EN: fixed priority instead of
// round-robin (no rotating pointer).
module ws2812b_write_arbiter
    import ws2812b_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NB_LEDS = DEFAULT_NB_LEDS,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*LED_IDX_W-1:0] req_start,
    input  logic [NUM_REQ*CNT_W-1:0]     req_count,
    input  logic [NUM_REQ*COLOR_W-1:0]   req_color,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [COLOR_W-1:0]           color,
    output logic [LED_IDX_W-1:0]         nb_led,
    output logic                         write,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t             state;
    logic [LED_IDX_W-1:0]   addr;
    logic [CNT_W-1:0]       remaining;
    logic [NUM_REQ-1:0]     grant_oh;
    logic [IDX_W-1:0]       pick_ptr;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [LED_IDX_W-1:0]   sel_start;
    logic [CNT_W-1:0]       sel_count;
    color_t                 sel_color;

    function automatic logic in_range(input logic [LED_IDX_W-1:0] a);
        return a < LED_IDX_W'(NB_LEDS);
    endfunction

`ifdef WS2812B_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
        return (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
    endfunction

    assign pick_ptr = rr_ptr;
`endif

    ws2812b_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid (req_valid),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign pick_any  = |pick_grant;
    assign sel_start = req_start[LED_IDX_W*pick_idx +: LED_IDX_W];
    assign sel_count = req_count[CNT_W*pick_idx +: CNT_W];
    assign sel_color = req_color[COLOR_W*pick_idx +: COLOR_W];

    // Arbitration FSM; the first slot is emitted on the grant edge so write
    // appears the cycle right after the request is sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            grant_oh  <= '0;
            req_ready <= '0;
            color     <= '0;
            nb_led    <= '0;
            write     <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= '0;
`ifndef WS2812B_ARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    write     <= 1'b0;
                    req_ready <= '0;
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        grant_oh <= pick_grant;
                        color    <= sel_color;
                        nb_led   <= sel_start;
                        busy     <= 1'b1;
                        if (sel_count == '0) begin
                            state     <= DONE;
                            req_ready <= pick_grant;
                            addr      <= sel_start;
                            remaining <= '0;
                        end else begin
                            state     <= WRITE;
                            write     <= in_range(sel_start);
                            addr      <= sel_start + 1'b1;
                            remaining <= sel_count - CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (remaining == '0) begin
                        state     <= DONE;
                        write     <= 1'b0;
                        req_ready <= grant_oh;
                    end else begin
                        nb_led    <= addr;
                        write     <= in_range(addr);
                        addr      <= addr + 1'b1;
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= '0;
                    busy      <= 1'b0;
`ifndef WS2812B_ARB_FIXED_PRIO_EN
                    rr_ptr    <= next_ptr(grant_id);
`endif
                end
                default: begin
                    state     <= IDLE;
                    write     <= 1'b0;
                    req_ready <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_write_arbiter.sv
// Directed bench for ws2812b_write_arbiter (NUM_REQ=4, NB_LEDS=5).
module tb_ws2812b_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int NB_LEDS = 5;
    localparam int CNT_W   = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ*32-1:0]  req_start = '0;
    logic [NUM_REQ*CNT_W-1:0] req_count = '0;
    logic [NUM_REQ*24-1:0]  req_color = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [23:0]            color;
    logic [31:0]            nb_led;
    logic                   write;
    logic                   busy;
    logic [1:0]             grant_id;

    int errs   = 0;
    int checks = 0;

    ws2812b_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NB_LEDS (NB_LEDS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_start (req_start),
        .req_count (req_count),
        .req_color (req_color),
        .req_ready (req_ready),
        .color     (color),
        .nb_led    (nb_led),
        .write     (write),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] s, input int n, input logic [23:0] c);
        req_start[32*i +: 32]       = s;
        req_count[CNT_W*i +: CNT_W] = CNT_W'(n);
        req_color[24*i +: 24]       = c;
        req_valid[i]                = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Call at a negedge right after the request becomes visible to the DUT.
    task automatic run_fill(input int id, input logic [31:0] start, input int count,
                            input logic [23:0] col, input bit drop);
        logic [31:0] a;
        for (int j = 0; j < count; j++) begin
            @(negedge clk);
            a = start + 32'(j);
            check("slot_write", write, a < 32'(NB_LEDS));
            check("slot_nb_led", nb_led, a);
            check("slot_color", color, col);
            check("slot_grant_id", grant_id, id);
            check("slot_busy", busy, 1);
            check("slot_ready_low", req_ready, 0);
        end
        @(negedge clk);
        check("done_write", write, 0);
        check("done_ready", req_ready, 4'b0001 << id);
        check("done_busy", busy, 1);
        check("done_grant_id", grant_id, id);
        if (drop) req_valid = '0;
        @(negedge clk);
        check("idle_ready", req_ready, 0);
        check("idle_busy", busy, 0);
        check("idle_write", write, 0);
    endtask

    logic [23:0] cols [NUM_REQ] = '{24'h110000, 24'h002200, 24'h000033, 24'h444444};

    initial begin
        int eid;

        // Reset state
        @(negedge clk);
        check("rst_write", write, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_nb_led", nb_led, 0);
        check("rst_color", color, 0);
        check("rst_grant_id", grant_id, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single request
        set_req(0, 32'd1, 3, 24'h00FF00);
        run_fill(0, 32'd1, 3, 24'h00FF00, 1'b1);

        // All four requesters at once, held for two rounds
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(i), 1, cols[i]);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
`ifdef WS2812B_ARB_FIXED_PRIO_EN
                eid = 0;
`else
                eid = i;
`endif
                run_fill(eid, 32'(eid), 1, cols[eid], (r == 1) && (i == NUM_REQ - 1));
            end
        end

        // Fill running past the strip end
        do_reset();
        set_req(1, 32'd3, 4, 24'hABCDEF);
        run_fill(1, 32'd3, 4, 24'hABCDEF, 1'b1);

        // Zero-length fill
        do_reset();
        set_req(2, 32'd2, 0, 24'h123456);
        run_fill(2, 32'd2, 0, 24'h123456, 1'b1);

        // Address wrap past 2^32 lands back on the strip
        do_reset();
        set_req(0, 32'hFFFF_FFFE, 4, 24'h0F0F0F);
        run_fill(0, 32'hFFFF_FFFE, 4, 24'h0F0F0F, 1'b1);

        // Reset mid-fill, then the held request restarts from scratch
        do_reset();
        set_req(3, 32'd0, 5, 24'h0000FF);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("pre_rst_write", write, 1);
            check("pre_rst_nb_led", nb_led, j);
        end
        #1 rst = 1'b0;
        #1;
        check("async_rst_write", write, 0);
        check("async_rst_ready", req_ready, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        run_fill(3, 32'd0, 5, 24'h0000FF, 1'b1);

        // Nothing pending: arbiter stays idle
        repeat (3) begin
            @(negedge clk);
            check("quiet_write", write, 0);
            check("quiet_busy", busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
